// File: rtl/cci_mpf_if_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cci_mpf_if_pkg
//  Description : Shared CCI widths, default buffer sizing and the C1 entry.
//  Revision    : 1.0
// ============================================================================
package cci_mpf_if_pkg;

    localparam int C_CCI_DATA_WIDTH        = 512;
    localparam int C_CCI_TX_HDR_WIDTH      = 61;
    localparam int C_CCI_RX_HDR_WIDTH      = 18;
    localparam int C_DEFAULT_DEPTH         = 16;
    localparam int C_DEFAULT_ALMFULL_SLACK = 4;

    typedef struct packed {
        logic [C_CCI_TX_HDR_WIDTH-1:0] hdr;
        logic [C_CCI_DATA_WIDTH-1:0]   data;
        logic                          wrValid;
        logic                          irValid;
    } t_c1_entry;

endpackage
`default_nettype wire

// File: rtl/cci_mpf_if.sv
`default_nettype none
// ============================================================================
//  Interface   : cci_mpf_if
//  Description : CCI request/response bundle with platform- and AFU-side views.
//  Revision    : 1.0
// ============================================================================
interface cci_mpf_if
    import cci_mpf_if_pkg::*;
#(
    parameter int CCI_DATA_WIDTH   = C_CCI_DATA_WIDTH,
    parameter int CCI_TX_HDR_WIDTH = C_CCI_TX_HDR_WIDTH,
    parameter int CCI_RX_HDR_WIDTH = C_CCI_RX_HDR_WIDTH
) ();

    logic                        resetb;

    logic [CCI_TX_HDR_WIDTH-1:0] C0TxHdr;
    logic                        C0TxRdValid;
    logic                        C0TxAlmFull;

    logic [CCI_TX_HDR_WIDTH-1:0] C1TxHdr;
    logic [CCI_DATA_WIDTH-1:0]   C1TxData;
    logic                        C1TxWrValid;
    logic                        C1TxIrValid;
    logic                        C1TxAlmFull;

    logic [CCI_RX_HDR_WIDTH-1:0] C0RxHdr;
    logic [CCI_DATA_WIDTH-1:0]   C0RxData;
    logic                        C0RxWrValid;
    logic                        C0RxRdValid;
    logic                        C0RxCgValid;
    logic                        C0RxUgValid;
    logic                        C0RxIrValid;

    logic [CCI_RX_HDR_WIDTH-1:0] C1RxHdr;
    logic                        C1RxWrValid;
    logic                        C1RxIrValid;

    // Seen from a module whose downstream neighbour is the platform
    modport to_qlp (
        output C0TxHdr, C0TxRdValid,
        output C1TxHdr, C1TxData, C1TxWrValid, C1TxIrValid,
        input  C0TxAlmFull, C1TxAlmFull,
        input  C0RxHdr, C0RxData, C0RxWrValid, C0RxRdValid, C0RxCgValid, C0RxUgValid, C0RxIrValid,
        input  C1RxHdr, C1RxWrValid, C1RxIrValid
    );

    // Seen from a module whose upstream neighbour is the AFU
    modport to_afu (
        output resetb,
        input  C0TxHdr, C0TxRdValid,
        input  C1TxHdr, C1TxData, C1TxWrValid, C1TxIrValid,
        output C0TxAlmFull, C1TxAlmFull,
        output C0RxHdr, C0RxData, C0RxWrValid, C0RxRdValid, C0RxCgValid, C0RxUgValid, C0RxIrValid,
        output C1RxHdr, C1RxWrValid, C1RxIrValid
    );

endinterface
`default_nettype wire

// File: rtl/cci_mpf_prim_fifo_lutram.sv
`default_nettype none
// ============================================================================
//  Module      : cci_mpf_prim_fifo_lutram
//  Description : Distributed-RAM FIFO with asynchronous head read; the caller
//                guarantees enqueue only when space exists (or a dequeue frees it).
//  Revision    : 1.0
// ============================================================================
module cci_mpf_prim_fifo_lutram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_enq,
    input  logic [WIDTH-1:0]         i_enq_data,
    input  logic                     i_deq,
    output logic [WIDTH-1:0]         o_first,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_notFull,
    output logic                     o_notEmpty
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    // At full with a simultaneous dequeue, wptr == rptr: the head is read
    // before the edge overwrites it, so both operations see correct data.
    always_ff @(posedge clk) begin
        if (i_enq) begin
            r_mem[r_wptr] <= i_enq_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_enq) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_deq) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (i_enq && !i_deq) begin
                r_count <= r_count + 1'b1;
            end else if (!i_enq && i_deq) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_first    = r_mem[r_rptr];
    assign o_count    = r_count;
    assign o_notFull  = (r_count != C_DEPTH);
    assign o_notEmpty = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/cci_mpf_shim_tx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : cci_mpf_shim_tx_buffer
//  Description : Per-channel Tx request buffering with AlmFull slack and an
//                empty-FIFO bypass, plus a one-cycle registered Rx stage.
//  Revision    : 1.0
// ============================================================================
module cci_mpf_shim_tx_buffer
    import cci_mpf_if_pkg::*;
#(
    parameter int C0_DEPTH         = C_DEFAULT_DEPTH,
    parameter int C1_DEPTH         = C_DEFAULT_DEPTH,
    parameter int ALMFULL_SLACK    = C_DEFAULT_ALMFULL_SLACK,
    parameter int CCI_DATA_WIDTH   = C_CCI_DATA_WIDTH,
    parameter int CCI_TX_HDR_WIDTH = C_CCI_TX_HDR_WIDTH,
    parameter int CCI_RX_HDR_WIDTH = C_CCI_RX_HDR_WIDTH
) (
    input  logic       clk,
    input  logic       resetb,
    cci_mpf_if.to_qlp  qlp,
    cci_mpf_if.to_afu  afu,
    output logic       c0_overflow,
    output logic       c1_overflow
);

    localparam int C0_CW = $clog2(C0_DEPTH) + 1;
    localparam int C1_CW = $clog2(C1_DEPTH) + 1;
    localparam int C1_W  = $bits(t_c1_entry);

    assign afu.resetb = resetb;

    // ---------------- C0 channel ----------------
    logic                        w_c0_enq, w_c0_deq, w_c0_bypass, w_c0_push;
    logic                        w_c0_notFull, w_c0_notEmpty;
    logic [CCI_TX_HDR_WIDTH-1:0] w_c0_first;
    logic [C0_CW-1:0]            w_c0_count, w_c0_count_next;
    logic                        r_c0_valid, r_c0_almFull, r_c0_overflow;
    logic [CCI_TX_HDR_WIDTH-1:0] r_c0_hdr;

    assign w_c0_enq        = afu.C0TxRdValid;
    assign w_c0_deq        = w_c0_notEmpty && !qlp.C0TxAlmFull;
    assign w_c0_bypass     = w_c0_enq && !w_c0_notEmpty && !qlp.C0TxAlmFull;
    assign w_c0_push       = w_c0_enq && !w_c0_bypass && (w_c0_notFull || w_c0_deq);
    assign w_c0_count_next = w_c0_count + C0_CW'(w_c0_push) - C0_CW'(w_c0_deq);

    cci_mpf_prim_fifo_lutram #(.WIDTH(CCI_TX_HDR_WIDTH), .DEPTH(C0_DEPTH)) u_c0_fifo (
        .clk        (clk),
        .rst_n      (resetb),
        .i_enq      (w_c0_push),
        .i_enq_data (afu.C0TxHdr),
        .i_deq      (w_c0_deq),
        .o_first    (w_c0_first),
        .o_count    (w_c0_count),
        .o_notFull  (w_c0_notFull),
        .o_notEmpty (w_c0_notEmpty)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_c0_valid    <= 1'b0;
            r_c0_almFull  <= 1'b1;
            r_c0_overflow <= 1'b0;
        end else begin
            r_c0_valid   <= w_c0_deq || w_c0_bypass;
            r_c0_almFull <= (C0_CW'(C0_DEPTH) - w_c0_count_next) <= C0_CW'(ALMFULL_SLACK);
            if (w_c0_enq && !w_c0_notFull && !w_c0_deq) begin
                r_c0_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_c0_hdr <= w_c0_notEmpty ? w_c0_first : afu.C0TxHdr;
    end

    // ---------------- C1 channel ----------------
    logic             w_c1_enq, w_c1_deq, w_c1_bypass, w_c1_push;
    logic             w_c1_notFull, w_c1_notEmpty;
    t_c1_entry        w_c1_in, w_c1_first;
    logic [C1_CW-1:0] w_c1_count, w_c1_count_next;
    logic             r_c1_valid, r_c1_almFull, r_c1_overflow;
    t_c1_entry        r_c1_ent;

    assign w_c1_in         = {afu.C1TxHdr, afu.C1TxData, afu.C1TxWrValid, afu.C1TxIrValid};
    assign w_c1_enq        = afu.C1TxWrValid || afu.C1TxIrValid;
    assign w_c1_deq        = w_c1_notEmpty && !qlp.C1TxAlmFull;
    assign w_c1_bypass     = w_c1_enq && !w_c1_notEmpty && !qlp.C1TxAlmFull;
    assign w_c1_push       = w_c1_enq && !w_c1_bypass && (w_c1_notFull || w_c1_deq);
    assign w_c1_count_next = w_c1_count + C1_CW'(w_c1_push) - C1_CW'(w_c1_deq);

    cci_mpf_prim_fifo_lutram #(.WIDTH(C1_W), .DEPTH(C1_DEPTH)) u_c1_fifo (
        .clk        (clk),
        .rst_n      (resetb),
        .i_enq      (w_c1_push),
        .i_enq_data (w_c1_in),
        .i_deq      (w_c1_deq),
        .o_first    (w_c1_first),
        .o_count    (w_c1_count),
        .o_notFull  (w_c1_notFull),
        .o_notEmpty (w_c1_notEmpty)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_c1_valid    <= 1'b0;
            r_c1_almFull  <= 1'b1;
            r_c1_overflow <= 1'b0;
        end else begin
            r_c1_valid   <= w_c1_deq || w_c1_bypass;
            r_c1_almFull <= (C1_CW'(C1_DEPTH) - w_c1_count_next) <= C1_CW'(ALMFULL_SLACK);
            if (w_c1_enq && !w_c1_notFull && !w_c1_deq) begin
                r_c1_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_c1_ent <= w_c1_notEmpty ? w_c1_first : w_c1_in;
    end

    assign qlp.C0TxRdValid = r_c0_valid;
    assign qlp.C0TxHdr     = r_c0_hdr;
    assign qlp.C1TxWrValid = r_c1_valid && r_c1_ent.wrValid;
    assign qlp.C1TxIrValid = r_c1_valid && r_c1_ent.irValid;
    assign qlp.C1TxHdr     = r_c1_ent.hdr;
    assign qlp.C1TxData    = r_c1_ent.data;
    assign afu.C0TxAlmFull = r_c0_almFull;
    assign afu.C1TxAlmFull = r_c1_almFull;
    assign c0_overflow     = r_c0_overflow;
    assign c1_overflow     = r_c1_overflow;

    // ---------------- Rx register stage ----------------
    logic                        r_rx0_wr, r_rx0_rd, r_rx0_cg, r_rx0_ug, r_rx0_ir;
    logic                        r_rx1_wr, r_rx1_ir;
    logic [CCI_RX_HDR_WIDTH-1:0] r_rx0_hdr, r_rx1_hdr;
    logic [CCI_DATA_WIDTH-1:0]   r_rx0_data;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            {r_rx0_wr, r_rx0_rd, r_rx0_cg, r_rx0_ug, r_rx0_ir} <= '0;
            {r_rx1_wr, r_rx1_ir}                               <= '0;
        end else begin
            {r_rx0_wr, r_rx0_rd, r_rx0_cg, r_rx0_ug, r_rx0_ir} <=
                {qlp.C0RxWrValid, qlp.C0RxRdValid, qlp.C0RxCgValid, qlp.C0RxUgValid, qlp.C0RxIrValid};
            {r_rx1_wr, r_rx1_ir} <= {qlp.C1RxWrValid, qlp.C1RxIrValid};
        end
    end

    always_ff @(posedge clk) begin
        r_rx0_hdr  <= qlp.C0RxHdr;
        r_rx0_data <= qlp.C0RxData;
        r_rx1_hdr  <= qlp.C1RxHdr;
    end

    assign afu.C0RxWrValid = r_rx0_wr;
    assign afu.C0RxRdValid = r_rx0_rd;
    assign afu.C0RxCgValid = r_rx0_cg;
    assign afu.C0RxUgValid = r_rx0_ug;
    assign afu.C0RxIrValid = r_rx0_ir;
    assign afu.C0RxHdr     = r_rx0_hdr;
    assign afu.C0RxData    = r_rx0_data;
    assign afu.C1RxWrValid = r_rx1_wr;
    assign afu.C1RxIrValid = r_rx1_ir;
    assign afu.C1RxHdr     = r_rx1_hdr;

endmodule
`default_nettype wire

// File: tb/tb_cci_mpf_shim_tx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cci_mpf_shim_tx_buffer
//  Description : Scenario and randomized checks of the Tx buffer shim against
//                a queue-based reference model.
//  Revision    : 1.0
// ============================================================================
module tb_cci_mpf_shim_tx_buffer;

    localparam int D  = 16;
    localparam int S  = 4;
    localparam int HW = 61;
    localparam int DW = 512;
    localparam int EW = HW + DW + 2;

    logic clk    = 1'b0;
    logic resetb = 1'b0;
    logic c0_overflow, c1_overflow;
    int   checks = 0;
    int   errors = 0;

    cci_mpf_if qlp_if ();
    cci_mpf_if afu_if ();

    cci_mpf_shim_tx_buffer #(.C0_DEPTH(D), .C1_DEPTH(D), .ALMFULL_SLACK(S)) dut (
        .clk         (clk),
        .resetb      (resetb),
        .qlp         (qlp_if),
        .afu         (afu_if),
        .c0_overflow (c0_overflow),
        .c1_overflow (c1_overflow)
    );

    always #5 clk = ~clk;
    assign qlp_if.resetb = resetb;

    // Reference model: one queue per channel, entries packed {hdr, data, wr, ir}
    logic [HW-1:0] m_c0q[$];
    logic [EW-1:0] m_c1q[$];
    logic          e_c0_v, e_c1_v, e_c0_af, e_c1_af, e_c0_ovf, e_c1_ovf;
    logic [HW-1:0] e_c0_hdr;
    logic [EW-1:0] e_c1_ent;

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic model_reset();
        m_c0q.delete();
        m_c1q.delete();
        e_c0_v = 1'b0;  e_c1_v = 1'b0;
        e_c0_af = 1'b1; e_c1_af = 1'b1;
        e_c0_ovf = 1'b0; e_c1_ovf = 1'b0;
        e_c0_hdr = '0;  e_c1_ent = '0;
    endtask

    task automatic drive_idle();
        afu_if.C0TxRdValid = 1'b0; afu_if.C0TxHdr = '0;
        afu_if.C1TxWrValid = 1'b0; afu_if.C1TxIrValid = 1'b0;
        afu_if.C1TxHdr = '0; afu_if.C1TxData = '0;
        qlp_if.C0TxAlmFull = 1'b0; qlp_if.C1TxAlmFull = 1'b0;
        qlp_if.C0RxHdr = '0; qlp_if.C0RxData = '0; qlp_if.C1RxHdr = '0;
        qlp_if.C0RxWrValid = 1'b0; qlp_if.C0RxRdValid = 1'b0; qlp_if.C0RxCgValid = 1'b0;
        qlp_if.C0RxUgValid = 1'b0; qlp_if.C0RxIrValid = 1'b0;
        qlp_if.C1RxWrValid = 1'b0; qlp_if.C1RxIrValid = 1'b0;
    endtask

    // Advance one clock, update the model from the inputs held at the edge
    task automatic step();
        @(posedge clk);
        if (!resetb) begin
            model_reset();
        end else begin
            if (afu_if.C0TxRdValid) begin
                if (m_c0q.size() < D || !qlp_if.C0TxAlmFull) m_c0q.push_back(afu_if.C0TxHdr);
                else e_c0_ovf = 1'b1;
            end
            e_c0_v = !qlp_if.C0TxAlmFull && (m_c0q.size() != 0);
            if (e_c0_v) e_c0_hdr = m_c0q.pop_front();
            e_c0_af = (D - m_c0q.size()) <= S;

            if (afu_if.C1TxWrValid || afu_if.C1TxIrValid) begin
                if (m_c1q.size() < D || !qlp_if.C1TxAlmFull)
                    m_c1q.push_back({afu_if.C1TxHdr, afu_if.C1TxData, afu_if.C1TxWrValid, afu_if.C1TxIrValid});
                else e_c1_ovf = 1'b1;
            end
            e_c1_v = !qlp_if.C1TxAlmFull && (m_c1q.size() != 0);
            if (e_c1_v) e_c1_ent = m_c1q.pop_front();
            e_c1_af = (D - m_c1q.size()) <= S;
        end
        #1;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        model_reset();
        drive_idle();
        repeat (2) step();
        resetb = 1'b1;
        step();
    endtask

    task automatic test_reset();
        drive_idle();
        resetb = 1'b0;
        model_reset();
        repeat (3) step();
        checks++;
        if ({qlp_if.C0TxRdValid, qlp_if.C1TxWrValid, qlp_if.C1TxIrValid} !== 3'b000) begin
            errors++; $display("FAIL reset_tx_valids: got %b expected 000",
                {qlp_if.C0TxRdValid, qlp_if.C1TxWrValid, qlp_if.C1TxIrValid});
        end
        checks++;
        if ({afu_if.C0TxAlmFull, afu_if.C1TxAlmFull} !== 2'b11) begin
            errors++; $display("FAIL reset_almfull: got %b expected 11", {afu_if.C0TxAlmFull, afu_if.C1TxAlmFull});
        end
        checks++;
        if ({c0_overflow, c1_overflow} !== 2'b00) begin
            errors++; $display("FAIL reset_overflow: got %b expected 00", {c0_overflow, c1_overflow});
        end
        checks++;
        if ({afu_if.C0RxRdValid, afu_if.C0RxWrValid, afu_if.C1RxWrValid, afu_if.C1RxIrValid} !== 4'b0000) begin
            errors++; $display("FAIL reset_rx_valids: got %b expected 0000",
                {afu_if.C0RxRdValid, afu_if.C0RxWrValid, afu_if.C1RxWrValid, afu_if.C1RxIrValid});
        end
        checks++;
        if (afu_if.resetb !== 1'b0) begin
            errors++; $display("FAIL reset_afu_resetb_low: got %b expected 0", afu_if.resetb);
        end
        resetb = 1'b1;
        #1;
        checks++;
        if (afu_if.resetb !== 1'b1) begin
            errors++; $display("FAIL reset_afu_resetb_high: got %b expected 1", afu_if.resetb);
        end
        step();
        checks++;
        if ({afu_if.C0TxAlmFull, afu_if.C1TxAlmFull} !== 2'b00) begin
            errors++; $display("FAIL reset_release_almfull: got %b expected 00", {afu_if.C0TxAlmFull, afu_if.C1TxAlmFull});
        end
    endtask

    task automatic test_passthrough();
        repeat (3) step();
        afu_if.C0TxRdValid = 1'b1;
        afu_if.C0TxHdr     = HW'(16'h1234);
        step();
        afu_if.C0TxRdValid = 1'b0;
        checks++;
        if (qlp_if.C0TxRdValid !== 1'b1 || qlp_if.C0TxHdr !== HW'(16'h1234)) begin
            errors++; $display("FAIL passthrough_c0: got v=%b hdr=%h expected v=1 hdr=1234",
                qlp_if.C0TxRdValid, qlp_if.C0TxHdr);
        end
        step();
        checks++;
        if (qlp_if.C0TxRdValid !== 1'b0) begin
            errors++; $display("FAIL passthrough_c0_idle: got v=%b expected 0", qlp_if.C0TxRdValid);
        end
    endtask

    task automatic test_rx();
        logic [DW-1:0] d;
        logic [17:0]   h1;
        d  = rand_data();
        h1 = 18'($urandom());
        qlp_if.C0RxRdValid = 1'b1; qlp_if.C0RxHdr = 18'h2A5; qlp_if.C0RxData = d;
        qlp_if.C1RxWrValid = 1'b1; qlp_if.C1RxHdr = h1;
        step();
        qlp_if.C0RxRdValid = 1'b0; qlp_if.C1RxWrValid = 1'b0;
        checks++;
        if (afu_if.C0RxRdValid !== 1'b1 || afu_if.C0RxHdr !== 18'h2A5 || afu_if.C0RxData !== d) begin
            errors++; $display("FAIL rx_c0: got v=%b hdr=%h data=%h expected v=1 hdr=2a5 data=%h",
                afu_if.C0RxRdValid, afu_if.C0RxHdr, afu_if.C0RxData, d);
        end
        checks++;
        if (afu_if.C1RxWrValid !== 1'b1 || afu_if.C1RxHdr !== h1) begin
            errors++; $display("FAIL rx_c1: got v=%b hdr=%h expected v=1 hdr=%h", afu_if.C1RxWrValid, afu_if.C1RxHdr, h1);
        end
        step();
        checks++;
        if (afu_if.C0RxRdValid !== 1'b0 || afu_if.C1RxWrValid !== 1'b0) begin
            errors++; $display("FAIL rx_idle: got c0=%b c1=%b expected 0 0", afu_if.C0RxRdValid, afu_if.C1RxWrValid);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] bp_data [12];
        do_reset();
        qlp_if.C1TxAlmFull = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            bp_data[k-1]       = rand_data();
            afu_if.C1TxWrValid = 1'b1;
            afu_if.C1TxHdr     = HW'(k);
            afu_if.C1TxData    = bp_data[k-1];
            step();
            checks++;
            if (afu_if.C1TxAlmFull !== (k >= 12) || qlp_if.C1TxWrValid !== 1'b0) begin
                errors++; $display("FAIL bp_fill k=%0d: got af=%b qv=%b expected af=%b qv=0",
                    k, afu_if.C1TxAlmFull, qlp_if.C1TxWrValid, k >= 12);
            end
        end
        afu_if.C1TxWrValid = 1'b0;
        checks++;
        if (c1_overflow !== 1'b0) begin
            errors++; $display("FAIL bp_overflow: got %b expected 0", c1_overflow);
        end
        qlp_if.C1TxAlmFull = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (qlp_if.C1TxWrValid !== 1'b1 || qlp_if.C1TxHdr !== HW'(i + 1) ||
                qlp_if.C1TxData !== bp_data[i] || afu_if.C1TxAlmFull !== 1'b0) begin
                errors++; $display("FAIL bp_drain i=%0d: got v=%b hdr=%0d af=%b expected v=1 hdr=%0d af=0",
                    i, qlp_if.C1TxWrValid, qlp_if.C1TxHdr, afu_if.C1TxAlmFull, i + 1);
            end
        end
        step();
        checks++;
        if (qlp_if.C1TxWrValid !== 1'b0) begin
            errors++; $display("FAIL bp_drain_end: got v=%b expected 0", qlp_if.C1TxWrValid);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        qlp_if.C1TxAlmFull = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            afu_if.C1TxWrValid = 1'b1; afu_if.C1TxHdr = HW'(k); afu_if.C1TxData = {16{32'(k)}};
            step();
        end
        afu_if.C1TxWrValid = 1'b0;
        checks++;
        if (c1_overflow !== 1'b1 || qlp_if.C1TxWrValid !== 1'b0 || afu_if.C1TxAlmFull !== 1'b1) begin
            errors++; $display("FAIL ovf_drop: got ovf=%b qv=%b af=%b expected 1 0 1",
                c1_overflow, qlp_if.C1TxWrValid, afu_if.C1TxAlmFull);
        end

        do_reset();
        qlp_if.C1TxAlmFull = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            afu_if.C1TxWrValid = 1'b1; afu_if.C1TxHdr = HW'(k); afu_if.C1TxData = {16{32'(k)}};
            step();
        end
        qlp_if.C1TxAlmFull = 1'b0;
        afu_if.C1TxHdr = HW'(17); afu_if.C1TxData = {16{32'(17)}};
        for (int i = 1; i <= 17; i++) begin
            step();
            afu_if.C1TxWrValid = 1'b0;
            checks++;
            if (qlp_if.C1TxWrValid !== 1'b1 || qlp_if.C1TxHdr !== HW'(i) || qlp_if.C1TxData !== {16{32'(i)}} ||
                c1_overflow !== 1'b0 || afu_if.C1TxAlmFull !== e_c1_af) begin
                errors++; $display("FAIL ovf_accept i=%0d: got v=%b hdr=%0d ovf=%b af=%b expected v=1 hdr=%0d ovf=0 af=%b",
                    i, qlp_if.C1TxWrValid, qlp_if.C1TxHdr, c1_overflow, afu_if.C1TxAlmFull, i, e_c1_af);
            end
        end
    endtask

    task automatic test_random();
        logic fill;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            fill = ((cyc / 75) % 2) == 0;
            afu_if.C0TxRdValid = fill ? ($urandom_range(3) != 0) : ($urandom_range(1) != 0);
            afu_if.C0TxHdr     = {29'($urandom()), 32'($urandom())};
            afu_if.C1TxWrValid = 1'($urandom_range(1));
            afu_if.C1TxIrValid = 1'($urandom_range(1));
            afu_if.C1TxHdr     = {29'($urandom()), 32'($urandom())};
            afu_if.C1TxData    = rand_data();
            qlp_if.C0TxAlmFull = fill ? ($urandom_range(7) != 0) : ($urandom_range(7) == 0);
            qlp_if.C1TxAlmFull = fill ? ($urandom_range(7) != 0) : ($urandom_range(7) == 0);
            step();
            checks++;
            if (qlp_if.C0TxRdValid !== e_c0_v || (e_c0_v && qlp_if.C0TxHdr !== e_c0_hdr)) begin
                errors++; $display("FAIL rnd_c0 cyc=%0d: got v=%b hdr=%h expected v=%b hdr=%h",
                    cyc, qlp_if.C0TxRdValid, qlp_if.C0TxHdr, e_c0_v, e_c0_hdr);
            end
            checks++;
            if (qlp_if.C1TxWrValid !== (e_c1_v && e_c1_ent[1]) || qlp_if.C1TxIrValid !== (e_c1_v && e_c1_ent[0]) ||
                (e_c1_v && {qlp_if.C1TxHdr, qlp_if.C1TxData} !== e_c1_ent[EW-1:2])) begin
                errors++; $display("FAIL rnd_c1 cyc=%0d: got wr=%b ir=%b hdr=%h expected v=%b wr=%b ir=%b hdr=%h",
                    cyc, qlp_if.C1TxWrValid, qlp_if.C1TxIrValid, qlp_if.C1TxHdr,
                    e_c1_v, e_c1_ent[1], e_c1_ent[0], e_c1_ent[EW-1 -: HW]);
            end
            checks++;
            if ({afu_if.C0TxAlmFull, afu_if.C1TxAlmFull} !== {e_c0_af, e_c1_af}) begin
                errors++; $display("FAIL rnd_almfull cyc=%0d: got %b%b expected %b%b",
                    cyc, afu_if.C0TxAlmFull, afu_if.C1TxAlmFull, e_c0_af, e_c1_af);
            end
            checks++;
            if ({c0_overflow, c1_overflow} !== {e_c0_ovf, e_c1_ovf}) begin
                errors++; $display("FAIL rnd_overflow cyc=%0d: got %b%b expected %b%b",
                    cyc, c0_overflow, c1_overflow, e_c0_ovf, e_c1_ovf);
            end
        end
        drive_idle();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        qlp_if.C0TxAlmFull = 1'b1;
        qlp_if.C1TxAlmFull = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            afu_if.C0TxRdValid = 1'b1; afu_if.C0TxHdr = HW'(100 + k);
            afu_if.C1TxWrValid = 1'b1; afu_if.C1TxHdr = HW'(200 + k);
            step();
        end
        afu_if.C0TxRdValid = 1'b0; afu_if.C1TxWrValid = 1'b0;
        qlp_if.C0TxAlmFull = 1'b0; qlp_if.C1TxAlmFull = 1'b0;
        step();
        checks++;
        if (qlp_if.C0TxRdValid !== 1'b1 || qlp_if.C0TxHdr !== HW'(101) || qlp_if.C1TxWrValid !== 1'b1) begin
            errors++; $display("FAIL mid_inflight: got c0v=%b hdr=%0d c1v=%b expected 1 101 1",
                qlp_if.C0TxRdValid, qlp_if.C0TxHdr, qlp_if.C1TxWrValid);
        end
        #2;
        resetb = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({qlp_if.C0TxRdValid, qlp_if.C1TxWrValid, qlp_if.C1TxIrValid} !== 3'b000 ||
            {afu_if.C0TxAlmFull, afu_if.C1TxAlmFull} !== 2'b11) begin
            errors++; $display("FAIL mid_async_reset: got valids=%b af=%b expected 000 11",
                {qlp_if.C0TxRdValid, qlp_if.C1TxWrValid, qlp_if.C1TxIrValid}, {afu_if.C0TxAlmFull, afu_if.C1TxAlmFull});
        end
        repeat (2) step();
        resetb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({qlp_if.C0TxRdValid, qlp_if.C1TxWrValid, qlp_if.C1TxIrValid} !== 3'b000) begin
                errors++; $display("FAIL mid_stale i=%0d: got valids=%b expected 000",
                    i, {qlp_if.C0TxRdValid, qlp_if.C1TxWrValid, qlp_if.C1TxIrValid});
            end
        end
        checks++;
        if ({afu_if.C0TxAlmFull, afu_if.C1TxAlmFull, c0_overflow, c1_overflow} !== 4'b0000) begin
            errors++; $display("FAIL mid_post_state: got af=%b%b ovf=%b%b expected 00 00",
                afu_if.C0TxAlmFull, afu_if.C1TxAlmFull, c0_overflow, c1_overflow);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_rx();
        test_backpressure();
        test_overflow();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
